// File: rtl/ahb_cmd_master_if.sv
// Command-side and AHB-Lite-side signal bundle for the single-transfer AHB command master.
// The master modport is the view of ahb_cmd_master; the slave modport is the view of whatever drives it.
interface ahb_cmd_master_if #(
    parameter int AWIDTH = 10
);
    logic              CMD_VALID;
    logic              CMD_READY;
    logic              CMD_WRITE;
    logic [AWIDTH-1:0] CMD_ADDR;
    logic [1:0]        CMD_SIZE;
    logic [31:0]       CMD_WDATA;
    logic              RSP_VALID;
    logic [31:0]       RSP_RDATA;
    logic              RSP_ERROR;
    logic [AWIDTH-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic              HMASTLOCK;
    logic [3:0]        HPROT;
    logic [31:0]       HWDATA;
    logic [31:0]       HRDATA;
    logic              HREADY;
    logic              HRESP;

    modport master (
        input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_SIZE, CMD_WDATA,
        input  HRDATA, HREADY, HRESP,
        output CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERROR,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HPROT, HWDATA
    );

    modport slave (
        output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_SIZE, CMD_WDATA,
        output HRDATA, HREADY, HRESP,
        input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERROR,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HPROT, HWDATA
    );
endinterface

// File: rtl/ahb_cmd_master.sv
// Turns one command at a time into a single non-overlapped AHB-Lite transfer and reports
// completion with a one-cycle response pulse; illegal or misaligned commands complete at once with an error.
module ahb_cmd_master #(
    parameter int          AWIDTH    = 10,
    parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
    input  logic                 HCLK,
    input  logic                 HRESETN,
    ahb_cmd_master_if.master     bus
);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        cmd_legal;
    logic [31:0] wdata_q;

    assign bus.CMD_READY = (state == IDLE);
    assign bus.HBURST    = 3'b000;
    assign bus.HMASTLOCK = 1'b0;
    assign bus.HPROT     = HPROT_VAL;

    // Halfwords need bit 0 clear, words need bits 1:0 clear; size 3 is never legal.
    always_comb begin
        cmd_legal = 1'b0;
        case (bus.CMD_SIZE)
            2'd0:    cmd_legal = 1'b1;
            2'd1:    cmd_legal = ~bus.CMD_ADDR[0];
            2'd2:    cmd_legal = (bus.CMD_ADDR[1:0] == 2'b00);
            default: cmd_legal = 1'b0;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.CMD_VALID && cmd_legal) state_next = ADDR;
            ADDR:    if (bus.HREADY) state_next = DATA;
            DATA:    if (bus.HREADY) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus and response registers; address-phase outputs simply hold while HREADY is low.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            bus.HADDR     <= '0;
            bus.HTRANS    <= HTRANS_IDLE;
            bus.HWRITE    <= 1'b0;
            bus.HSIZE     <= 3'b000;
            bus.HWDATA    <= 32'h0;
            bus.RSP_VALID <= 1'b0;
            bus.RSP_RDATA <= 32'h0;
            bus.RSP_ERROR <= 1'b0;
            wdata_q       <= 32'h0;
        end else begin
            bus.RSP_VALID <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.CMD_VALID) begin
                        if (cmd_legal) begin
                            bus.HADDR  <= bus.CMD_ADDR;
                            bus.HWRITE <= bus.CMD_WRITE;
                            bus.HSIZE  <= {1'b0, bus.CMD_SIZE};
                            bus.HTRANS <= HTRANS_NONSEQ;
                            wdata_q    <= bus.CMD_WDATA;
                        end else begin
                            bus.RSP_VALID <= 1'b1;
                            bus.RSP_ERROR <= 1'b1;
                            bus.RSP_RDATA <= 32'h0;
                        end
                    end
                end
                ADDR: begin
                    if (bus.HREADY) begin
                        bus.HTRANS <= HTRANS_IDLE;
                        if (bus.HWRITE) bus.HWDATA <= wdata_q;
                    end
                end
                DATA: begin
                    // A low HREADY here may be the first half of an ERROR response, so HRESP is ignored until HREADY rises.
                    if (bus.HREADY) begin
                        if (!bus.HWRITE) bus.RSP_RDATA <= bus.HRDATA;
                        bus.RSP_ERROR <= bus.HRESP;
                        bus.RSP_VALID <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_cmd_master.sv
// Directed bench for ahb_cmd_master: a scripted zero/wait-state slave, expected responses queued at
// command time and compared whenever RSP_VALID pulses.
module tb_ahb_cmd_master;
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic HCLK;
    logic HRESETN;

    int   assertion_count = 0;
    int   failure_count   = 0;
    int   cycle           = 0;
    int   rsp_count       = 0;
    int   rsp_before      = 0;
    rsp_t sb[$];
    int   nonseq_q[$];
    logic [1:0] prev_htrans = 2'b00;

    ahb_cmd_master_if #(.AWIDTH(10)) bus ();

    ahb_cmd_master #(
        .AWIDTH   (10),
        .HPROT_VAL(4'b0011)
    ) dut (
        .HCLK   (HCLK),
        .HRESETN(HRESETN),
        .bus    (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertion_count++;
        assert (observed === expected)
        else begin
            failure_count++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One clock edge, then sample; any response pulse is matched against the head of the scoreboard.
    task automatic tick();
        rsp_t r;
        @(posedge HCLK);
        #1;
        cycle++;
        if (bus.HTRANS == 2'b10 && prev_htrans != 2'b10) nonseq_q.push_back(cycle);
        prev_htrans = bus.HTRANS;
        if (bus.RSP_VALID === 1'b1) begin
            rsp_count++;
            assertion_count++;
            assert (sb.size() != 0)
            else begin
                failure_count++;
                $error("[TB] FAIL unexpected_rsp: observed RSP_VALID=1 expected no pending response");
            end
            if (sb.size() != 0) begin
                r = sb.pop_front();
                check_output("rsp_rdata", bus.RSP_RDATA, r.rdata);
                check_output("rsp_error", {31'b0, bus.RSP_ERROR}, {31'b0, r.err});
            end
        end
    endtask

    task automatic apply_stimulus(input logic wr, input logic [9:0] addr, input logic [1:0] size,
                                  input logic [31:0] wdata, input logic push,
                                  input logic [31:0] exp_rdata, input logic exp_err);
        bus.CMD_VALID = 1'b1;
        bus.CMD_WRITE = wr;
        bus.CMD_ADDR  = addr;
        bus.CMD_SIZE  = size;
        bus.CMD_WDATA = wdata;
        if (push) sb.push_back('{rdata: exp_rdata, err: exp_err});
        tick();
        bus.CMD_VALID = 1'b0;
    endtask

    task automatic check_reset_values(input string phase);
        check_output({phase, "_htrans"},    {30'b0, bus.HTRANS}, 32'h0);
        check_output({phase, "_haddr"},     {22'b0, bus.HADDR}, 32'h0);
        check_output({phase, "_hwrite"},    {31'b0, bus.HWRITE}, 32'h0);
        check_output({phase, "_hsize"},     {29'b0, bus.HSIZE}, 32'h0);
        check_output({phase, "_hwdata"},    bus.HWDATA, 32'h0);
        check_output({phase, "_rsp_valid"}, {31'b0, bus.RSP_VALID}, 32'h0);
        check_output({phase, "_rsp_rdata"}, bus.RSP_RDATA, 32'h0);
        check_output({phase, "_rsp_error"}, {31'b0, bus.RSP_ERROR}, 32'h0);
        check_output({phase, "_cmd_ready"}, {31'b0, bus.CMD_READY}, 32'h1);
    endtask

    initial begin
        HRESETN       = 1'b0;
        bus.CMD_VALID = 1'b1;
        bus.CMD_WRITE = 1'b1;
        bus.CMD_ADDR  = 10'h008;
        bus.CMD_SIZE  = 2'd2;
        bus.CMD_WDATA = 32'h11111111;
        bus.HRDATA    = 32'h0;
        bus.HREADY    = 1'b1;
        bus.HRESP     = 1'b0;

        // Reset: a valid command must not be taken while HRESETN is low
        tick();
        tick();
        check_reset_values("reset");
        check_output("reset_hburst",    {29'b0, bus.HBURST}, 32'h0);
        check_output("reset_hmastlock", {31'b0, bus.HMASTLOCK}, 32'h0);
        check_output("reset_hprot",     {28'b0, bus.HPROT}, 32'h3);
        HRESETN       = 1'b1;
        bus.CMD_VALID = 1'b0;
        tick();
        check_output("post_reset_htrans", {30'b0, bus.HTRANS}, 32'h0);

        // Zero-wait word write
        $display("[TB] zero-wait write");
        apply_stimulus(1'b1, 10'h010, 2'd2, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
        check_output("wr_htrans_nonseq", {30'b0, bus.HTRANS}, 32'h2);
        check_output("wr_haddr",         {22'b0, bus.HADDR}, 32'h010);
        check_output("wr_hwrite",        {31'b0, bus.HWRITE}, 32'h1);
        check_output("wr_hsize",         {29'b0, bus.HSIZE}, 32'h2);
        check_output("wr_cmd_ready",     {31'b0, bus.CMD_READY}, 32'h0);
        tick();
        check_output("wr_htrans_idle",   {30'b0, bus.HTRANS}, 32'h0);
        check_output("wr_hwdata",        bus.HWDATA, 32'hDEADBEEF);
        check_output("wr_rsp_early",     {31'b0, bus.RSP_VALID}, 32'h0);
        tick();
        check_output("wr_rsp_valid",     {31'b0, bus.RSP_VALID}, 32'h1);
        tick();
        check_output("wr_rsp_clear",     {31'b0, bus.RSP_VALID}, 32'h0);
        check_output("wr_haddr_hold",    {22'b0, bus.HADDR}, 32'h010);
        check_output("wr_ready_again",   {31'b0, bus.CMD_READY}, 32'h1);

        // Read with two data-phase wait states
        $display("[TB] read with wait states");
        apply_stimulus(1'b0, 10'h020, 2'd2, 32'h0, 1'b1, 32'h12345678, 1'b0);
        check_output("rd_hwrite", {31'b0, bus.HWRITE}, 32'h0);
        tick();
        bus.HREADY = 1'b0;
        tick();
        check_output("rd_wait1_rsp", {31'b0, bus.RSP_VALID}, 32'h0);
        tick();
        check_output("rd_wait2_rsp", {31'b0, bus.RSP_VALID}, 32'h0);
        check_output("rd_wait2_ready", {31'b0, bus.CMD_READY}, 32'h0);
        bus.HREADY = 1'b1;
        bus.HRDATA = 32'h12345678;
        tick();
        check_output("rd_rsp_valid", {31'b0, bus.RSP_VALID}, 32'h1);
        bus.HRDATA = 32'h0;
        tick();
        check_output("rd_rsp_clear", {31'b0, bus.RSP_VALID}, 32'h0);
        check_output("rd_rdata_hold", bus.RSP_RDATA, 32'h12345678);

        // Misaligned halfword and illegal size complete immediately with error
        $display("[TB] illegal commands");
        apply_stimulus(1'b0, 10'h003, 2'd1, 32'h0, 1'b1, 32'h0, 1'b1);
        check_output("mis_htrans", {30'b0, bus.HTRANS}, 32'h0);
        check_output("mis_rsp_valid", {31'b0, bus.RSP_VALID}, 32'h1);
        check_output("mis_ready", {31'b0, bus.CMD_READY}, 32'h1);
        tick();
        check_output("mis_rsp_clear", {31'b0, bus.RSP_VALID}, 32'h0);
        apply_stimulus(1'b1, 10'h000, 2'd3, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b1);
        check_output("sz3_htrans", {30'b0, bus.HTRANS}, 32'h0);
        check_output("sz3_haddr_hold", {22'b0, bus.HADDR}, 32'h020);
        tick();
        apply_stimulus(1'b1, 10'h006, 2'd2, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b1);
        check_output("misw_htrans", {30'b0, bus.HTRANS}, 32'h0);
        tick();

        // ERROR response, with one address-phase wait state first
        $display("[TB] error response");
        apply_stimulus(1'b1, 10'h030, 2'd1, 32'h5555A5A5, 1'b1, 32'h0, 1'b1);
        bus.HREADY = 1'b0;
        tick();
        check_output("err_addr_hold_htrans", {30'b0, bus.HTRANS}, 32'h2);
        check_output("err_addr_hold_haddr", {22'b0, bus.HADDR}, 32'h030);
        check_output("err_addr_hold_hsize", {29'b0, bus.HSIZE}, 32'h1);
        bus.HREADY = 1'b1;
        tick();
        check_output("err_hwdata", bus.HWDATA, 32'h5555A5A5);
        bus.HREADY = 1'b0;
        bus.HRESP  = 1'b1;
        tick();
        check_output("err_first_cycle_rsp", {31'b0, bus.RSP_VALID}, 32'h0);
        bus.HREADY = 1'b1;
        tick();
        check_output("err_rsp_valid", {31'b0, bus.RSP_VALID}, 32'h1);
        bus.HRESP = 1'b0;
        tick();
        check_output("err_rsp_clear", {31'b0, bus.RSP_VALID}, 32'h0);
        check_output("err_error_hold", {31'b0, bus.RSP_ERROR}, 32'h1);

        // Reset in the data phase aborts the transfer without a response
        $display("[TB] reset mid-transfer");
        apply_stimulus(1'b0, 10'h041, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        check_output("abort_nonseq", {30'b0, bus.HTRANS}, 32'h2);
        tick();
        bus.HREADY = 1'b0;
        tick();
        check_output("abort_in_data", {31'b0, bus.CMD_READY}, 32'h0);
        HRESETN = 1'b0;
        #1;
        check_reset_values("abort");
        tick();
        tick();
        HRESETN     = 1'b1;
        bus.HREADY  = 1'b1;
        bus.HRDATA  = 32'hCAFEF00D;
        apply_stimulus(1'b0, 10'h004, 2'd2, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0);
        check_output("after_abort_htrans", {30'b0, bus.HTRANS}, 32'h2);
        check_output("after_abort_haddr", {22'b0, bus.HADDR}, 32'h004);
        tick();
        tick();
        check_output("after_abort_rsp", {31'b0, bus.RSP_VALID}, 32'h1);
        tick();

        // Back-to-back writes with CMD_VALID held high
        $display("[TB] back-to-back writes");
        nonseq_q.delete();
        rsp_before    = rsp_count;
        bus.CMD_VALID = 1'b1;
        bus.CMD_WRITE = 1'b1;
        bus.CMD_SIZE  = 2'd2;
        for (int i = 0; i < 4; i++) begin
            bus.CMD_ADDR  = 10'h100 + 10'(i * 4);
            bus.CMD_WDATA = 32'hB0B00000 + 32'(i);
            sb.push_back('{rdata: 32'hCAFEF00D, err: 1'b0});
            check_output("b2b_ready", {31'b0, bus.CMD_READY}, 32'h1);
            tick();
            check_output("b2b_haddr", {22'b0, bus.HADDR}, 32'h100 + 32'(i * 4));
            tick();
            check_output("b2b_hwdata", bus.HWDATA, 32'hB0B00000 + 32'(i));
            if (i == 3) bus.CMD_VALID = 1'b0;
            tick();
        end
        tick();
        tick();
        check_output("b2b_nonseq_count", 32'(nonseq_q.size()), 32'd4);
        for (int i = 1; i < nonseq_q.size(); i++) begin
            check_output("b2b_spacing", 32'(nonseq_q[i] - nonseq_q[i-1]), 32'd3);
        end
        check_output("b2b_rsp_pulses", 32'(rsp_count - rsp_before), 32'd4);
        check_output("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertion_count, failure_count);
        $finish;
    end
endmodule

// File: doc/ahb_cmd_master.md
AHB_CMD_MASTER -- requirements
Module: ahb_cmd_master

Interface
REQ-001 The block SHALL have one clock, HCLK, and one reset, HRESETN; the reset SHALL be asynchronous and active-low.
REQ-002 The block SHALL have these parameters: AWIDTH, default 10, address width; HPROT_VAL, default 4'b0011, constant HPROT value.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
  HCLK  in  1  bus clock
  HRESETN  in  1  async active-low reset
  CMD_VALID  in  1  command request
  CMD_READY  out  1  command accept
  CMD_WRITE  in  1  1=write, 0=read
  CMD_ADDR  in  AWIDTH  byte address
  CMD_SIZE  in  2  0=byte, 1=halfword, 2=word, 3=illegal
  CMD_WDATA  in  32  write data
  RSP_VALID  out  1  one-cycle completion pulse
  RSP_RDATA  out  32  read data
  RSP_ERROR  out  1  error or misaligned completion
  HADDR  out  AWIDTH  AHB address
  HTRANS  out  2  AHB transfer type (IDLE=00, NONSEQ=10)
  HWRITE  out  1  AHB direction
  HSIZE  out  3  AHB size
  HBURST  out  3  AHB burst type, constant 3'b000 (SINGLE)
  HMASTLOCK  out  1  AHB lock, constant 0
  HPROT  out  4  AHB protection, constant HPROT_VAL
  HWDATA  out  32  AHB write data
  HRDATA  in  32  AHB read data
  HREADY  in  1  AHB ready
  HRESP  in  1  AHB response (1=ERROR)

Function
REQ-004 The FSM SHALL have three states: IDLE, ADDR, DATA; each transfer is a single transfer, with no overlap between a transfer's data phase and the next address phase.
REQ-005 CMD_READY SHALL be 1 exactly when the state is IDLE; a command SHALL be accepted on an HCLK rising edge where CMD_VALID, CMD_READY and HRESETN are all 1.
REQ-006 An accepted command SHALL be legal if CMD_SIZE<3 and the address is aligned: halfword requires CMD_ADDR[0]=0; word requires CMD_ADDR[1:0]=0.
REQ-007 For a legal command, on the accept edge the block SHALL:
  - register HADDR=CMD_ADDR, HWRITE=CMD_WRITE, HSIZE={1'b0,CMD_SIZE} and HTRANS=NONSEQ;
  - capture CMD_WDATA internally;
  - move to ADDR.
REQ-008 In ADDR, on an edge with HREADY=1 the block SHALL:
  - set HTRANS=IDLE;
  - drive HWDATA with the captured data if HWRITE=1 (HWDATA is unchanged for reads);
  - move to DATA.
  On an edge with HREADY=0 it SHALL hold all address-phase outputs and stay in ADDR.
REQ-009 In DATA, on an edge with HREADY=1 the block SHALL:
  - capture RSP_RDATA=HRDATA for reads (RSP_RDATA is unchanged for writes);
  - set RSP_ERROR=HRESP and RSP_VALID=1;
  - move to IDLE.
  On an edge with HREADY=0 it SHALL stay in DATA, whatever the value of HRESP (first cycle of a two-cycle ERROR response).
REQ-010 For an illegal command, on the accept edge the block SHALL:
  - stay in IDLE and leave HTRANS=IDLE;
  - set RSP_VALID=1, RSP_ERROR=1 and RSP_RDATA=0;
  - issue no bus transfer.
REQ-011 RSP_VALID SHALL be high for exactly one cycle per accepted command and SHALL clear on the next edge; RSP_RDATA and RSP_ERROR SHALL hold their value until the next completion.
REQ-012 Latency with a zero-wait slave SHALL be: accept edge E0; NONSEQ between E0 and E1; data phase between E1 and E2; RSP_VALID=1 after E2. Each wait state SHALL add one cycle. An illegal command SHALL give RSP_VALID=1 after E0.
REQ-013 The earliest next accept SHALL be the edge that ends the RSP_VALID cycle, so back-to-back zero-wait transfers run at one every 3 cycles.
REQ-014 HADDR, HWRITE and HSIZE SHALL hold their last values while in IDLE; HTRANS SHALL be IDLE in every state except ADDR.

Reset
REQ-015 While HRESETN=0 the block SHALL be in state IDLE with these values, applied asynchronously:
  - HTRANS=00, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0;
  - RSP_VALID=0, RSP_RDATA=0, RSP_ERROR=0;
  - HBURST=0, HMASTLOCK=0, HPROT=HPROT_VAL.
REQ-016 While HRESETN=0, CMD_READY SHALL be 1 (the state is IDLE) but no command SHALL be accepted.
REQ-017 Reset asserted in ADDR or DATA SHALL abort the transfer: HTRANS=IDLE at once, no RSP_VALID pulse, and the first command after release starts cleanly from IDLE.

Verification
REQ-018 Zero-wait write: CMD_WRITE=1, CMD_ADDR=0x010, CMD_SIZE=2, CMD_WDATA=0xDEADBEEF -> HTRANS=NONSEQ and HADDR=0x010 for one cycle, HWDATA=0xDEADBEEF in the next cycle, RSP_VALID=1 and RSP_ERROR=0 three cycles after accept.
REQ-019 Read with 2 wait states: CMD_ADDR=0x020, CMD_SIZE=2; slave holds HREADY=0 for 2 data-phase cycles, then returns HRDATA=0x12345678 -> RSP_RDATA=0x12345678, RSP_VALID 5 cycles after accept.
REQ-020 ERROR response: slave gives HREADY=0/HRESP=1, then HREADY=1/HRESP=1 -> RSP_ERROR=1 on a single RSP_VALID pulse.
REQ-021 Misaligned command: CMD_SIZE=1, CMD_ADDR=0x003 -> HTRANS stays IDLE throughout, RSP_VALID=1, RSP_ERROR=1 and RSP_RDATA=0 one cycle after accept; same response for CMD_SIZE=3.
REQ-022 Reset mid-transfer: HRESETN driven low during DATA with HREADY=0 -> all outputs at their reset values at once and no RSP_VALID; after release, a zero-wait read to 0x004 completes normally.
REQ-023 Back-to-back: CMD_VALID held high for 4 legal writes to zero-wait slave -> 4 NONSEQ cycles exactly 3 cycles apart and 4 RSP_VALID pulses.
